// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI types, burst/response codes and the
// FSM state encodings used by the memory responder.
package axi_pkg;

   localparam int ID_W_DEF = 4;

   typedef logic [ID_W_DEF-1:0] axi_id_t;
   typedef logic [1:0]          axi_resp_t;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_BURST
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_t;

   function automatic logic burst_ok(input logic [1:0] b);
      return (b == BURST_FIXED) || (b == BURST_INCR);
   endfunction

endpackage

// File: rtl/axi_resp_mem.sv
// axi_resp_mem: word array with one byte-strobed write port
// and one combinational read port (read-before-write).
module axi_resp_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 subordinate memory model with
// independent single-outstanding read and write engines.
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 4,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [1:0]          arburst,
   output logic                rvalid,
   input  logic                rready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast
);

   localparam int OFF = $clog2(DATA_W/8);
   localparam int MA  = $clog2(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

   typedef struct packed {
      r_state_t    st;
      logic        arready;
      logic        rvalid;
      logic        rlast;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      axi_resp_t   resp;
      logic [ADDR_W-1:0] idx;
      logic [7:0]  cnt;
      logic [7:0]  len;
      logic [1:0]  burst;
   } rd_t;

   typedef struct packed {
      w_state_t    st;
      logic        awready;
      logic        wready;
      logic        bvalid;
      logic [ID_W-1:0] bid;
      axi_resp_t   bresp;
      logic [ADDR_W-1:0] idx;
      logic [8:0]  cnt;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic        err;
   } wr_t;

   rd_t rq, rd;
   wr_t wq, wd;

   logic [ADDR_W-1:0] ar_idx, aw_idx;
   logic [ADDR_W-1:0] rd_idx, r_nxt_idx, w_nxt_idx;
   logic [1:0]        r_burst_sel;
   logic              r_ok, w_ok, m_we;
   logic [DATA_W-1:0] m_rdata, f_data;
   axi_resp_t         f_resp;

   assign ar_idx = araddr >> OFF;
   assign aw_idx = awaddr >> OFF;

   axi_resp_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH),
      .AW     (MA)
   ) u_mem (
      .clk   (clk),
      .we    (m_we),
      .waddr (wq.idx[MA-1:0]),
      .wdata (wdata),
      .wstrb (wstrb),
      .raddr (rd_idx[MA-1:0]),
      .rdata (m_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rq <= '0;
         wq <= '0;
      end else begin
         rq <= rd;
         wq <= wd;
      end
   end

   // In idle the fetch uses araddr so beat 0 is ready at T+1.
   always_comb begin
      rd          = rq;
      r_nxt_idx   = (rq.burst == BURST_FIXED) ? rq.idx
                                              : rq.idx + 1'b1;
      rd_idx      = (rq.st == R_IDLE) ? ar_idx : r_nxt_idx;
      r_burst_sel = (rq.st == R_IDLE) ? arburst : rq.burst;
      r_ok        = burst_ok(r_burst_sel) && (rd_idx < DEPTH_A);
      f_data      = r_ok ? m_rdata : '0;
      f_resp      = r_ok ? RESP_OKAY : RESP_SLVERR;
      case (rq.st)
         R_IDLE: begin
            rd.arready = 1'b1;
            if (arvalid && rq.arready) begin
               rd.st      = R_BURST;
               rd.arready = 1'b0;
               rd.rvalid  = 1'b1;
               rd.id      = arid;
               rd.idx     = ar_idx;
               rd.cnt     = 8'd0;
               rd.len     = arlen;
               rd.burst   = arburst;
               rd.rlast   = (arlen == 8'd0);
               rd.data    = f_data;
               rd.resp    = f_resp;
            end
         end
         R_BURST: begin
            if (rready) begin
               if (rq.rlast) begin
                  rd.st      = R_IDLE;
                  rd.rvalid  = 1'b0;
                  rd.rlast   = 1'b0;
                  rd.arready = 1'b1;
                  rd.id      = '0;
                  rd.data    = '0;
                  rd.resp    = RESP_OKAY;
               end else begin
                  rd.cnt   = rq.cnt + 8'd1;
                  rd.idx   = r_nxt_idx;
                  rd.data  = f_data;
                  rd.resp  = f_resp;
                  rd.rlast = (rq.cnt + 8'd1 == rq.len);
               end
            end
         end
         default: rd = '0;
      endcase
   end

   always_comb begin
      wd        = wq;
      m_we      = 1'b0;
      w_nxt_idx = (wq.burst == BURST_FIXED) ? wq.idx
                                            : wq.idx + 1'b1;
      w_ok      = (wq.cnt <= {1'b0, wq.len})
                  && burst_ok(wq.burst)
                  && (wq.idx < DEPTH_A);
      case (wq.st)
         W_IDLE: begin
            wd.awready = 1'b1;
            if (awvalid && wq.awready) begin
               wd.st      = W_DATA;
               wd.awready = 1'b0;
               wd.wready  = 1'b1;
               wd.bid     = awid;
               wd.idx     = aw_idx;
               wd.cnt     = 9'd0;
               wd.len     = awlen;
               wd.burst   = awburst;
               wd.err     = 1'b0;
            end
         end
         W_DATA: begin
            if (wvalid && wq.wready) begin
               m_we   = w_ok && !rst;
               wd.idx = w_nxt_idx;
               wd.cnt = (&wq.cnt) ? wq.cnt : wq.cnt + 9'd1;
               if (!w_ok || (wlast && wq.cnt != {1'b0, wq.len})) begin
                  wd.err = 1'b1;
               end
               if (wlast) begin
                  wd.st     = W_RESP;
                  wd.wready = 1'b0;
                  wd.bvalid = 1'b1;
                  wd.bresp  = wd.err ? RESP_SLVERR : RESP_OKAY;
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               wd.st      = W_IDLE;
               wd.bvalid  = 1'b0;
               wd.bid     = '0;
               wd.bresp   = RESP_OKAY;
               wd.awready = 1'b1;
            end
         end
         default: wd = '0;
      endcase
   end

   assign arready = rq.arready;
   assign rvalid  = rq.rvalid;
   assign rid     = rq.id;
   assign rdata   = rq.data;
   assign rresp   = rq.resp;
   assign rlast   = rq.rlast;
   assign awready = wq.awready;
   assign wready  = wq.wready;
   assign bvalid  = wq.bvalid;
   assign bid     = wq.bid;
   assign bresp   = wq.bresp;

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: table vectors, corner sequences and
// randomized bursts checked against a word-array model.
module tb_axi_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [1:0]  awburst = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [7:0]  arlen = '0;
   logic [1:0]  arburst = '0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [0:1023];
   logic [31:0] wd_buf  [0:299];
   logic [3:0]  ws_buf  [0:299];

   typedef struct {
      logic [31:0] addr;
      int          len;
      logic [1:0]  burst;
      int          nb;
      logic [31:0] base;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] rb_addr;
      logic [31:0] rb_exp;
   } vec_t;

   vec_t tbl [8];

   axi_mem_responder dut (
      .clk     (clk),
      .rst     (rst),
      .awvalid (awvalid),
      .awready (awready),
      .awid    (awid),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awburst (awburst),
      .wvalid  (wvalid),
      .wready  (wready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .bvalid  (bvalid),
      .bready  (bready),
      .bid     (bid),
      .bresp   (bresp),
      .arvalid (arvalid),
      .arready (arready),
      .arid    (arid),
      .araddr  (araddr),
      .arlen   (arlen),
      .arburst (arburst),
      .rvalid  (rvalid),
      .rready  (rready),
      .rid     (rid),
      .rdata   (rdata),
      .rresp   (rresp),
      .rlast   (rlast)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_write(input logic [3:0] id,
                           input logic [31:0] addr,
                           input int len, input logic [1:0] burst,
                           input int nb, input bit gaps,
                           output logic [1:0] got);
      logic [1:0] exp;
      int idx, n;
      exp = 2'b00;
      if (burst > 2'd1 || nb != len + 1) exp = 2'b10;
      for (int b = 0; b < nb; b++) begin
         idx = int'(addr >> 2) + ((burst == 2'd1) ? b : 0);
         if (b > len || idx >= 1024) exp = 2'b10;
         else if (burst <= 2'd1)
            for (int k = 0; k < 4; k++)
               if (ws_buf[b][k])
                  ref_mem[idx][k*8 +: 8] = wd_buf[b][k*8 +: 8];
      end
      got = 2'bxx;
      chk("wready_idle", wready, 0);
      awvalid = 1'b1; awid = id; awaddr = addr;
      awlen = 8'(len); awburst = burst;
      n = 0;
      while (awready !== 1'b1 && n < 50) begin
         tick(); n++;
      end
      chk("aw_wait", n < 50, 1);
      tick();
      awvalid = 1'b0;
      chk("wready_after_aw", wready, 1);
      for (int b = 0; b < nb; b++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            wvalid = 1'b0;
            tick();
         end
         wvalid = 1'b1; wdata = wd_buf[b]; wstrb = ws_buf[b];
         wlast = (b == nb - 1);
         chk("wready_beat", wready, 1);
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_after_wlast", bvalid, 1);
      chk("wready_after_wlast", wready, 0);
      chk("bid", bid, id);
      chk("bresp", bresp, exp);
      got = bresp;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk("bvalid_hold", bvalid, 1);
         end
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("bvalid_drop", bvalid, 0);
      chk("awready_back", awready, 1);
   endtask

   task automatic do_read(input logic [3:0] id,
                          input logic [31:0] addr,
                          input int len, input logic [1:0] burst,
                          input int mode,
                          output logic [31:0] first);
      int b, cyc, idx, n;
      logic [31:0] ed;
      logic [1:0] er;
      bit rr;
      first = '0;
      arvalid = 1'b1; arid = id; araddr = addr;
      arlen = 8'(len); arburst = burst; rready = 1'b0;
      n = 0;
      while (arready !== 1'b1 && n < 50) begin
         tick(); n++;
      end
      chk("ar_wait", n < 50, 1);
      tick();
      arvalid = 1'b0;
      chk("rvalid_t1", rvalid, 1);
      b = 0; cyc = 0;
      while (b <= len && cyc < 40 * (len + 1) + 10) begin
         idx = int'(addr >> 2) + ((burst == 2'd1) ? b : 0);
         if (burst > 2'd1 || idx >= 1024) begin
            ed = '0; er = 2'b10;
         end else begin
            ed = ref_mem[idx]; er = 2'b00;
         end
         chk("rvalid", rvalid, 1);
         chk("rdata", rdata, ed);
         chk("rresp", rresp, er);
         chk("rlast", rlast, (b == len));
         chk("rid", rid, id);
         if (b == 0) first = rdata;
         case (mode)
            0:       rr = 1'b1;
            1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         rready = rr;
         tick();
         if (rr) b++;
         cyc++;
      end
      rready = 1'b0;
      chk("read_beats", b, len + 1);
      chk("rvalid_end", rvalid, 0);
      chk("arready_after_rlast", arready, 1);
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] first;
      logic [31:0] addr;
      int len, nb, w, r;
      logic [1:0] burst;

      tbl[0] = '{32'h10,  3, 2'd1, 4, 32'hA0,       4'hF,
                 2'b00, 32'h1C,  32'hA3};
      tbl[1] = '{32'h0,   0, 2'd1, 1, 32'h11223344, 4'hF,
                 2'b00, 32'h0,   32'h11223344};
      tbl[2] = '{32'h0,   0, 2'd1, 1, 32'hFFFFFFFF, 4'h2,
                 2'b00, 32'h0,   32'h1122FF44};
      tbl[3] = '{32'h20,  2, 2'd0, 3, 32'h55000000, 4'hF,
                 2'b00, 32'h20,  32'h55000002};
      tbl[4] = '{32'h10,  1, 2'd2, 2, 32'hDEAD0000, 4'hF,
                 2'b10, 32'h10,  32'hA0};
      tbl[5] = '{32'hFFC, 1, 2'd1, 2, 32'h77,       4'hF,
                 2'b10, 32'hFFC, 32'h77};
      tbl[6] = '{32'h40,  1, 2'd1, 3, 32'h300,      4'hF,
                 2'b10, 32'h44,  32'h301};
      tbl[7] = '{32'h50,  3, 2'd1, 2, 32'h400,      4'hF,
                 2'b10, 32'h54,  32'h401};

      repeat (3) tick();
      chk("reset_outputs",
          {awready, wready, bvalid, bid, bresp, arready,
           rvalid, rid, rdata, rresp, rlast}, 0);
      rst = 1'b0;
      tick();
      chk("arready_after_reset", arready, 1);
      chk("awready_after_reset", awready, 1);

      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 256; i++) begin
            wd_buf[i] = 32'hC0DE0000 | 32'(blk * 256 + i);
            ws_buf[i] = 4'hF;
         end
         do_write(4'd1, 32'(blk * 1024), 255, 2'd1, 256, 1'b0, resp);
      end

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < tbl[t].nb; i++) begin
            wd_buf[i] = tbl[t].base + 32'(i);
            ws_buf[i] = tbl[t].strb;
         end
         do_write(4'(t + 2), tbl[t].addr, tbl[t].len, tbl[t].burst,
                  tbl[t].nb, 1'b0, resp);
         chk($sformatf("tbl%0d_bresp", t), resp, tbl[t].exp_resp);
         do_read(4'(t), tbl[t].rb_addr, 0, 2'd1, 0, first);
         chk($sformatf("tbl%0d_readback", t), first, tbl[t].rb_exp);
      end

      do_read(4'd5, 32'h10, 3, 2'd1, 0, first);
      chk("incr_read_first", first, 32'hA0);
      do_read(4'd6, 32'h10, 3, 2'd1, 1, first);
      do_read(4'd7, 32'hFFC, 1, 2'd1, 0, first);
      do_read(4'd8, 32'h20, 2, 2'd0, 1, first);
      do_read(4'd9, 32'h30, 1, 2'd2, 0, first);

      arvalid = 1'b1; arid = 4'd3; araddr = 32'h100;
      arlen = 8'd7; arburst = 2'd1; rready = 1'b1;
      tick();
      arvalid = 1'b0;
      tick();
      tick();
      chk("beat2_before_rst", rdata, ref_mem[66]);
      rst = 1'b1;
      tick();
      chk("rvalid_in_rst", rvalid, 0);
      chk("arready_in_rst", arready, 0);
      rst = 1'b0;
      rready = 1'b0;
      tick();
      chk("arready_after_rst", arready, 1);
      chk("rvalid_after_rst", rvalid, 0);
      do_read(4'd4, 32'h100, 7, 2'd1, 2, first);

      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         burst = (r < 6) ? 2'd1 : (r < 8) ? 2'd0 : 2'd2;
         len = $urandom_range(0, 7);
         nb = len + 1;
         if ($urandom_range(0, 7) == 0)
            nb = ($urandom_range(0, 1) == 1) ? len + 2
                                              : ((len > 0) ? len : 1);
         w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255)
                                         : 1016 + $urandom_range(0, 8);
         addr = 32'(w << 2) | 32'($urandom_range(0, 3));
         for (int i = 0; i < nb; i++) begin
            wd_buf[i] = $urandom;
            ws_buf[i] = 4'($urandom_range(0, 15));
         end
         do_write(4'($urandom_range(0, 15)), addr, len, burst, nb,
                  1'b1, resp);
         r = $urandom_range(0, 9);
         burst = (r < 6) ? 2'd1 : (r < 8) ? 2'd0 : 2'd2;
         len = $urandom_range(0, 7);
         w = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255)
                                         : 1016 + $urandom_range(0, 8);
         addr = 32'(w << 2) | 32'($urandom_range(0, 3));
         do_read(4'($urandom_range(0, 15)), addr, len, burst, 2, first);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
